// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake and registered-ALU operand/result bundle for alu_op_sequencer.
// The master side is the sequencer; the slave side is the command source, sink and ALU.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [1:0]       cmd_fun;

    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [1:0]       ALU_FUN;
    logic [WIDTH:0]   ALU_OUT;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic [1:0]       rsp_fun;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun, ALU_OUT, rsp_ready,
        output cmd_ready, ALU_A, ALU_B, ALU_FUN,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_fun
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_fun, ALU_OUT, rsp_ready,
        input  cmd_ready, ALU_A, ALU_B, ALU_FUN,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_fun
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to a registered ALU, waits out its latency and returns the
// sliced result with carry/zero flags on a valid/ready response port.
module alu_op_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_op_sequencer_if.master seq_if,
    output logic               busy_o,
    output logic [CNT_W-1:0]   op_count_o
);
    localparam int unsigned LatW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [LatW-1:0]  lat_q, lat_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_fun_q, alu_fun_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [1:0]       rsp_fun_q, rsp_fun_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready;
    logic             load;

    // In RESP the port reopens only when the pending response drains this same edge.
    always_comb begin
        cmd_ready = 1'b0;
        if (!rst_i) begin
            if (state_q == StIdle) begin
                cmd_ready = 1'b1;
            end else if (state_q == StResp) begin
                cmd_ready = seq_if.rsp_ready;
            end
        end
    end

    assign load = seq_if.cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_fun_d    = alu_fun_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_fun_d    = rsp_fun_q;
        cnt_d        = cnt_q;

        if (load) begin
            alu_a_d   = seq_if.cmd_a;
            alu_b_d   = seq_if.cmd_b;
            alu_fun_d = seq_if.cmd_fun;
            lat_d     = LatW'(ALU_LAT);
        end

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    rsp_result_d = seq_if.ALU_OUT[WIDTH-1:0];
                    // Carry is meaningless for the logic functions.
                    rsp_carry_d  = alu_fun_q[1] ? 1'b0 : seq_if.ALU_OUT[WIDTH];
                    rsp_zero_d   = (seq_if.ALU_OUT[WIDTH-1:0] == '0);
                    rsp_fun_d    = alu_fun_q;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (seq_if.rsp_ready) begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = load ? StWait : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fun_q    <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_fun_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_fun_q    <= alu_fun_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_fun_q    <= rsp_fun_d;
            cnt_q        <= cnt_d;
        end
    end

    assign seq_if.cmd_ready  = cmd_ready;
    assign seq_if.ALU_A      = alu_a_q;
    assign seq_if.ALU_B      = alu_b_q;
    assign seq_if.ALU_FUN    = alu_fun_q;
    assign seq_if.rsp_valid  = (state_q == StResp);
    assign seq_if.rsp_result = rsp_result_q;
    assign seq_if.rsp_carry  = rsp_carry_q;
    assign seq_if.rsp_zero   = rsp_zero_q;
    assign seq_if.rsp_fun    = rsp_fun_q;
    assign busy_o            = (state_q != StIdle);
    assign op_count_o        = cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-stage registered ALU model attached.
// A second instance with a 2-bit counter exercises op_count saturation.
module tb_alu_op_sequencer;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();
    alu_op_sequencer_if #(.WIDTH(W)) sat_if ();
    logic          busy;
    logic [15:0]   op_count;
    logic          sat_busy;
    logic [1:0]    sat_cnt;

    alu_op_sequencer #(.WIDTH(W), .ALU_LAT(1), .CNT_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .seq_if     (bus),
        .busy_o     (busy),
        .op_count_o (op_count)
    );

    alu_op_sequencer #(.WIDTH(W), .ALU_LAT(1), .CNT_W(2)) dut_sat (
        .clk_i      (clk),
        .rst_i      (rst),
        .seq_if     (sat_if),
        .busy_o     (sat_busy),
        .op_count_o (sat_cnt)
    );

    // Bit 16 is left noisy for logic ops so the sequencer must mask it itself.
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] f);
        case (f)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {a[15], a & b};
            default: return {a[15], a | b};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ALU_OUT    <= '0;
            sat_if.ALU_OUT <= '0;
        end else begin
            bus.ALU_OUT    <= alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
            sat_if.ALU_OUT <= alu_f(sat_if.ALU_A, sat_if.ALU_B, sat_if.ALU_FUN);
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  fun;
        logic [15:0] res;
        logic        carry;
        logic        zero;
    } vec_t;

    vec_t vecs[8];
    vec_t q[4];
    int   nchecks = 0;
    int   nerr    = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f,
                         output int lat);
        int guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_fun   = f;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        exp_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;
        int idx;
        int nresp;
        int last_acc;
        int hs_cnt;
        logic acc;
        logic hs;

        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_fun = '0;
        bus.rsp_ready = 1'b0;
        sat_if.cmd_valid = 1'b0;
        sat_if.cmd_a = 16'd1;
        sat_if.cmd_b = 16'd1;
        sat_if.cmd_fun = 2'b00;
        sat_if.rsp_ready = 1'b1;

        vecs[0] = '{16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 1'b0, 1'b0};
        vecs[3] = '{16'hF0F0, 16'h0FF0, 2'b11, 16'hFFF0, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0007, 2'b01, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h1234, 16'h4321, 2'b00, 16'h5555, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'hFFFF, 2'b01, 16'h0001, 1'b1, 1'b0};

        q[0] = '{16'h0001, 16'h0002, 2'b00, 16'h0003, 1'b0, 1'b0};
        q[1] = '{16'h000A, 16'h0003, 2'b01, 16'h0007, 1'b0, 1'b0};
        q[2] = '{16'h00FF, 16'hFF00, 2'b11, 16'hFFFF, 1'b0, 1'b0};
        q[3] = '{16'hAAAA, 16'h5555, 2'b10, 16'h0000, 1'b0, 1'b1};

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_alu_a", {16'd0, bus.ALU_A}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].fun, lat);
            check($sformatf("v%0d_latency", i), lat, 32'd2);
            check($sformatf("v%0d_result", i), {16'd0, bus.rsp_result}, {16'd0, vecs[i].res});
            check($sformatf("v%0d_carry", i), {31'd0, bus.rsp_carry}, {31'd0, vecs[i].carry});
            check($sformatf("v%0d_zero", i), {31'd0, bus.rsp_zero}, {31'd0, vecs[i].zero});
            check($sformatf("v%0d_fun", i), {30'd0, bus.rsp_fun}, {30'd0, vecs[i].fun});
            check($sformatf("v%0d_resp_cmd_ready", i), {31'd0, bus.cmd_ready}, 32'd0);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            consume();
            check($sformatf("v%0d_op_count", i), {16'd0, op_count}, exp_cnt);
            check($sformatf("v%0d_valid_drop", i), {31'd0, bus.rsp_valid}, 32'd0);
            check($sformatf("v%0d_alu_a_held", i), {16'd0, bus.ALU_A}, {16'd0, vecs[i].a});
            check($sformatf("v%0d_alu_fun_held", i), {30'd0, bus.ALU_FUN}, {30'd0, vecs[i].fun});
        end

        // Backpressure: response held, stray command ignored
        issue(16'd5, 16'd7, 2'b01, lat);
        check("bp_latency", lat, 32'd2);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_result", {16'd0, bus.rsp_result}, 32'h0000FFFE);
            check("bp_carry", {31'd0, bus.rsp_carry}, 32'd1);
            check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            if (k == 1) begin
                bus.cmd_a = 16'h0001;
                bus.cmd_b = 16'h0001;
                bus.cmd_fun = 2'b00;
                bus.cmd_valid = 1'b1;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("bp_alu_a_held", {16'd0, bus.ALU_A}, 32'd5);
        check("bp_alu_fun_held", {30'd0, bus.ALU_FUN}, 32'd1);
        consume();
        check("bp_op_count", {16'd0, op_count}, exp_cnt);
        check("bp_no_stray_op", {31'd0, busy}, 32'd0);

        // Reset during WAIT
        @(negedge clk);
        bus.cmd_a = 16'h0009;
        bus.cmd_b = 16'h0009;
        bus.cmd_fun = 2'b00;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        check("mid_rst_alu_a", {16'd0, bus.ALU_A}, 32'd0);
        check("mid_rst_result", {16'd0, bus.rsp_result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("mid_no_response", seen, 32'd0);
        check("mid_op_count_after", {16'd0, op_count}, 32'd0);
        issue(16'h1234, 16'h1111, 2'b00, lat);
        check("post_rst_latency", lat, 32'd2);
        check("post_rst_result", {16'd0, bus.rsp_result}, 32'h00002345);
        consume();
        check("post_rst_op_count", {16'd0, op_count}, exp_cnt);

        // Back-to-back with rsp_ready held high
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        bus.cmd_a = q[0].a;
        bus.cmd_b = q[0].b;
        bus.cmd_fun = q[0].fun;
        bus.cmd_valid = 1'b1;
        idx = 0;
        nresp = 0;
        last_acc = -1;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            @(negedge clk);
            acc = bus.cmd_valid && bus.cmd_ready;
            hs = bus.rsp_valid && bus.rsp_ready;
            if (hs) begin
                check("b2b_result", {16'd0, bus.rsp_result}, {16'd0, q[nresp].res});
                check("b2b_zero", {31'd0, bus.rsp_zero}, {31'd0, q[nresp].zero});
                check("b2b_fun", {30'd0, bus.rsp_fun}, {30'd0, q[nresp].fun});
                nresp++;
                exp_cnt++;
            end
            if (acc) begin
                if (idx > 0) check("b2b_spacing", c - last_acc, 32'd3);
                last_acc = c;
                idx++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (idx < 4) begin
                    bus.cmd_a = q[idx].a;
                    bus.cmd_b = q[idx].b;
                    bus.cmd_fun = q[idx].fun;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_responses", nresp, 32'd4);
        check("b2b_accepts", idx, 32'd4);
        check("b2b_op_count", {16'd0, op_count}, exp_cnt);

        // Saturating counter on the 2-bit instance
        hs_cnt = 0;
        @(negedge clk);
        sat_if.cmd_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("sat_count", {30'd0, sat_cnt}, (hs_cnt > 3) ? 32'd3 : hs_cnt);
            if (sat_if.rsp_valid && sat_if.rsp_ready) hs_cnt++;
        end
        sat_if.cmd_valid = 1'b0;
        check("sat_enough_ops", {31'd0, hs_cnt >= 6}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
